// File: rtl/uart_rx_hs_pkg.sv
// Shared definitions for the handshake UART receiver: parity mode codes,
// receiver state encoding and a small parity-mode helper.
`timescale 1ns/1ps
package uart_rx_hs_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Mode 2'b11 is reserved and behaves as "no parity bit on the line".
    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_hs_if.sv
// Valid/ready byte-stream interface between the UART receiver (master)
// and its consumer (slave), carrying the per-word status flags.
`timescale 1ns/1ps
interface uart_rx_hs_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_break;

    modport master (
        output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_break,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_break,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_hs_sampler.sv
// Line conditioning for the receiver: 2-flop synchronizer, 3-deep history
// of synchronized samples, majority-vote bit value and falling-edge strobe.
`timescale 1ns/1ps
module uart_rx_hs_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic sample_bit,
    output logic fall
);

    logic [1:0] sync_q;
    logic [2:0] hist_q;

    // Synchronize the async pin and keep the last three synchronized samples;
    // everything presets to the idle-high level so reset release is quiet.
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], rx};
            hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    assign sample_bit = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    // hist_q[0] is the previous synchronized sample, sync_q[1] the current one.
    assign fall = hist_q[0] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_hs.sv
// UART receiver with mid-bit majority sampling, parity/framing checks and a
// valid/ready output register that flags overrun instead of losing a held word.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
`timescale 1ns/1ps
module uart_rx_hs
    import uart_rx_hs_pkg::*;
#(
    parameter int CLK_FREQ  = 1_000_000,
    parameter int BAUD_RATE = 10_000,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [1:0]  parity_mode,
    uart_rx_hs_if.master rx_bus
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CNT_W      = $clog2(BIT_CYCLES);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    logic sample_bit;
    logic fall;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic             start_frame;
    logic             sample_en;
    logic             frame_done;
    logic             mid_bit;

    logic [1:0]           mode_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 ferr_q;
    logic                 load_q;
    logic                 perr_calc;

    logic [DATA_BITS-1:0] word_q;
    logic                 valid_q;
    logic                 perr_out_q;
    logic                 ferr_out_q;
    logic                 ovr_q;
`ifdef UART_RX_BREAK_DET_EN
    logic                 zero_q;
    logic                 brk_q;
`endif

    uart_rx_hs_sampler u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .sample_bit (sample_bit),
        .fall       (fall)
    );

    assign mid_bit = (cnt_q == BIT_LAST);

    // State register plus bit-time and bit-index counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // Frame sequencing: start validation at half a bit, then one sample per
    // full bit time through data, optional parity and stop bits.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        start_frame = 1'b0;
        sample_en   = 1'b0;
        frame_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d     = ST_START;
                    cnt_d       = '0;
                    start_frame = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sample_bit ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                cnt_d = mid_bit ? '0 : cnt_q + 1'b1;
                if (mid_bit) begin
                    sample_en = 1'b1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = has_parity(mode_q) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                cnt_d = mid_bit ? '0 : cnt_q + 1'b1;
                if (mid_bit) begin
                    sample_en = 1'b1;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_d = mid_bit ? '0 : cnt_q + 1'b1;
                if (mid_bit) begin
                    sample_en = 1'b1;
                    if (bit_q == STOP_LAST) begin
                        bit_d      = '0;
                        frame_done = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        state_d = (zero_q & ~sample_bit) ? ST_BREAK : ST_IDLE;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            ST_BREAK: begin
                if (sample_bit) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame datapath: latch parity mode at the start edge, shift data LSB
    // first, capture the parity bit and accumulate stop-bit errors.
    // NOTE: the shift register and flags are reset as well, so an abandoned
    // frame can never leak stale bits into the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= PARITY_NONE;
            shift_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            load_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_q  <= 1'b1;
`endif
        end else begin
            load_q <= frame_done;
            if (start_frame) begin
                mode_q <= parity_mode;
                par_q  <= 1'b0;
                ferr_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                zero_q <= 1'b1;
`endif
            end
            if (sample_en) begin
`ifdef UART_RX_BREAK_DET_EN
                zero_q <= zero_q & ~sample_bit;
`endif
                if (state_q == ST_DATA) begin
                    shift_q <= {sample_bit, shift_q[DATA_BITS-1:1]};
                end else if (state_q == ST_PARITY) begin
                    par_q <= sample_bit;
                end else if (!sample_bit) begin
                    ferr_q <= 1'b1;
                end
            end
        end
    end

    // Parity verdict for the completed frame, evaluated in the load cycle.
    always_comb begin
        perr_calc = 1'b0;
        if (mode_q == PARITY_EVEN) begin
            perr_calc = ^{shift_q, par_q};
        end else if (mode_q == PARITY_ODD) begin
            perr_calc = ~(^{shift_q, par_q});
        end
    end

    // Output register: load a finished frame when the slot is free or being
    // accepted this cycle; otherwise drop it and flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q      <= 1'b0;
`endif
        end else if (load_q) begin
            if (!valid_q || rx_bus.rx_ready) begin
                valid_q    <= 1'b1;
                ovr_q      <= 1'b0;
                word_q     <= shift_q;
                perr_out_q <= perr_calc;
                ferr_out_q <= ferr_q;
`ifdef UART_RX_BREAK_DET_EN
                brk_q      <= zero_q;
                if (zero_q) begin
                    word_q     <= '0;
                    perr_out_q <= 1'b0;
                    ferr_out_q <= 1'b1;
                end
`endif
            end else begin
                ovr_q <= 1'b1;
            end
        end else if (valid_q && rx_bus.rx_ready) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign rx_bus.rx_data       = word_q;
    assign rx_bus.rx_valid      = valid_q;
    assign rx_bus.rx_parity_err = perr_out_q;
    assign rx_bus.rx_frame_err  = ferr_out_q;
    assign rx_bus.rx_overrun    = ovr_q;
`ifdef UART_RX_BREAK_DET_EN
    assign rx_bus.rx_break      = brk_q;
`else
    assign rx_bus.rx_break      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_hs.sv
// Self-checking bench for uart_rx_hs: directed frames plus randomized traffic,
// compared against a frame-level model of what each word must contain and
// when it must appear. Honours UART_RX_BREAK_DET_EN for the break scenario.
`timescale 1ns/1ps
module tb_uart_rx_hs;

    localparam int BIT = 100;   // 1 MHz / 10 kbaud

`ifdef UART_RX_BREAK_DET_EN
    localparam logic BRK_EXP = 1'b1;
`else
    localparam logic BRK_EXP = 1'b0;
`endif

    typedef struct {
        logic [10:0] word;   // {data, parity_err, frame_err, break}
        int          due;    // cycle at which rx_valid should rise
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [1:0] parity_mode;
    int         cyc = 0;
    int         ready_mode = 2;  // 0 random, 1 low, 2 high
    int         n_checks = 0;
    int         n_pass = 0;

    exp_t        exp_q[$];
    logic [10:0] got_q[$];
    exp_t        cur;
    logic        have_cur = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_acc = 1'b0;

    uart_rx_hs_if #(.DATA_BITS(8)) bus ();

    uart_rx_hs #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (10_000),
        .DATA_BITS (8),
        .STOP_BITS (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .parity_mode (parity_mode),
        .rx_bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.rx_ready = ($urandom_range(0, 3) != 0);
            1:       bus.rx_ready = 1'b0;
            default: bus.rx_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [10:0] dut_word();
        return {bus.rx_data, bus.rx_parity_err, bus.rx_frame_err, bus.rx_break};
    endfunction

    function automatic logic [12:0] dut_outputs();
        return {bus.rx_data, bus.rx_valid, bus.rx_parity_err, bus.rx_frame_err,
                bus.rx_overrun, bus.rx_break};
    endfunction

    function automatic logic model_has_par(input logic [1:0] mode);
        return (mode == 2'b01) || (mode == 2'b10);
    endfunction

    // What a normal frame must report, straight from the line bits sent.
    function automatic logic [10:0] model_word(input logic [7:0] d, input logic [1:0] mode,
                                               input logic pbit, input logic stop_v);
        logic ones_odd;
        logic perr;
        ones_odd = (^d) ^ pbit;
        perr = (mode == 2'b01) ? ones_odd : (mode == 2'b10) ? ~ones_odd : 1'b0;
        return {d, perr, ~stop_v, 1'b0};
    endfunction

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic pbit,
                              input logic stop_v, input bit expect_word);
        exp_t e;
        int   nbits;
        parity_mode = mode;
        @(posedge clk);
        #1;
        nbits = 10 + (model_has_par(mode) ? 1 : 0);
        if (expect_word) begin
            e.word = model_word(d, mode, pbit, stop_v);
            e.due  = cyc + nbits * BIT - BIT / 2 + 3;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (model_has_par(mode)) drive_bit(pbit);
        drive_bit(stop_v);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every cycle a word is held: a newly presented word must be the next
    // one the model predicts, on time, and must stay intact until accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            have_cur   = 1'b0;
        end else begin
            if (bus.rx_valid) begin
                if (!prev_valid || prev_acc) begin
                    got_q.push_back(dut_word());
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_word: got %h, expected no word (cycle %0d)",
                                 dut_word(), cyc);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                        n_checks++;
                        if (cyc >= cur.due - 1 && cyc <= cur.due + 2) n_pass++;
                        else $display("FAIL latency: valid at cycle %0d, expected %0d..%0d",
                                      cyc, cur.due - 1, cur.due + 2);
                    end
                end
                if (have_cur) check("held_word", 32'(dut_word()), 32'(cur.word));
            end
            prev_valid = bus.rx_valid;
            prev_acc   = bus.rx_valid && bus.rx_ready;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;
        logic [7:0] rd;
        logic [1:0] rm;
        logic       rp;
        logic       rs;
        exp_t       e;

        rst_n = 1'b0;
        rx = 1'b1;
        parity_mode = 2'b00;
        ready_mode = 2;
        idle(5);
        check("reset_outputs", 32'(dut_outputs()), 32'h0);
        rst_n = 1'b1;
        idle(20);

        // 1: plain frames, back to back.
        send_frame(8'hAA, 2'b00, 1'b0, 1'b1, 1'b1);
        send_frame(8'h55, 2'b00, 1'b0, 1'b1, 1'b1);
        idle(20);
        check("t1_count", 32'(got_q.size()), 32'd2);
        check("t1_aa", 32'(got_q[0]), 32'({8'hAA, 3'b000}));
        check("t1_55", 32'(got_q[1]), 32'({8'h55, 3'b000}));

        // 2: parity modes.
        send_frame(8'h5A, 2'b01, 1'b0, 1'b1, 1'b1);
        idle(50);
        check("t2_even_ok", 32'(got_q[$]), 32'({8'h5A, 3'b000}));
        send_frame(8'h5A, 2'b01, 1'b1, 1'b1, 1'b1);
        idle(50);
        check("t2_even_bad", 32'(got_q[$]), 32'({8'h5A, 3'b100}));
        send_frame(8'h5A, 2'b10, 1'b1, 1'b1, 1'b1);
        idle(50);
        check("t2_odd_ok", 32'(got_q[$]), 32'({8'h5A, 3'b000}));

        // 3: framing error, then a short glitch that must not start a frame.
        send_frame(8'h33, 2'b00, 1'b0, 1'b0, 1'b1);
        idle(50);
        check("t3_frame_err", 32'(got_q[$]), 32'({8'h33, 3'b010}));
        n_before = got_q.size();
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(300);
        check("t3_glitch_no_word", 32'(got_q.size()), 32'(n_before));
        check("t3_glitch_valid", 32'(bus.rx_valid), 32'd0);

        // 4: stalled consumer, second frame dropped with overrun.
        ready_mode = 1;
        idle(5);
        send_frame(8'h11, 2'b00, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b1, 1'b0);
        idle(20);
        check("t4_held_data", 32'(bus.rx_data), 32'h11);
        check("t4_overrun", 32'(bus.rx_overrun), 32'd1);
        check("t4_valid", 32'(bus.rx_valid), 32'd1);
        ready_mode = 2;
        @(negedge clk);
        for (int i = 0; i < 5 && !bus.rx_ready; i++) @(negedge clk);
        @(negedge clk);
        check("t4_accept_clears", 32'({bus.rx_valid, bus.rx_overrun}), 32'd0);
        idle(20);

        // 5: line held low for 15 bit times.
        parity_mode = 2'b00;
        @(posedge clk);
        #1;
        e.word = {8'h00, 1'b0, 1'b1, BRK_EXP};
        e.due  = cyc + 10 * BIT - BIT / 2 + 3;
        exp_q.push_back(e);
        n_before = got_q.size();
        rx = 1'b0;
        idle(15 * BIT);
        rx = 1'b1;
        idle(300);
        check("t5_one_word", 32'(got_q.size()), 32'(n_before + 1));
        check("t5_break_word", 32'(got_q[$]), 32'({8'h00, 1'b0, 1'b1, BRK_EXP}));
        send_frame(8'h7E, 2'b00, 1'b0, 1'b1, 1'b1);
        idle(50);
        check("t5_after_break", 32'(got_q[$]), 32'({8'h7E, 3'b000}));

        // 6: reset in the middle of a frame while a word is held.
        ready_mode = 1;
        idle(5);
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1);
        idle(50);
        check("t6_held_before_reset", 32'({bus.rx_valid, bus.rx_data}), 32'h1A5);
        fork
            send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b0);
            begin
                repeat (1 + 5 * BIT + BIT / 2) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                check("t6_reset_outputs", 32'(dut_outputs()), 32'h0);
            end
        join
        idle(20);
        rst_n = 1'b1;
        ready_mode = 0;
        idle(200);
        n_before = got_q.size();
        send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1);
        idle(50);
        check("t6_after_reset_count", 32'(got_q.size()), 32'(n_before + 1));
        check("t6_after_reset", 32'(got_q[$]), 32'({8'h3C, 3'b000}));

        // Randomized traffic with a jittery consumer.
        ready_mode = 0;
        for (int n = 0; n < 20; n++) begin
            rd = 8'($urandom);
            rm = 2'($urandom);
            rp = (^rd) ^ (rm == 2'b10) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 7) != 0) || (rd == 8'h00);
            send_frame(rd, rm, rp, rs, 1'b1);
            idle(rs ? $urandom_range(0, 150) : $urandom_range(20, 150));
        end
        idle(200);
        check("all_words_delivered", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
